punc_mem_bridge: RTL
====================

PUNC_MEM_BRIDGE -- requirements
Module: punc_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd255, max cycles mem_req held awaiting mem_ack; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  PUnC memory request; sampled only in IDLE.
REQ-005 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  input  16  word address; sampled with cpu_req.
REQ-007 cpu_wdata  input  16  write data; sampled with cpu_req.
REQ-008 cpu_rdata  output  16  last completed read data.
REQ-009 cpu_done  output  1  one-cycle pulse: transaction finished.
REQ-010 cpu_busy  output  1  high whenever state is not IDLE.
REQ-011 mem_req  output  1  external memory request, high only in REQ.
REQ-012 mem_we  output  1  latched cpu_we.
REQ-013 mem_addr  output  16  latched cpu_addr.
REQ-014 mem_wdata  output  16  latched cpu_wdata.
REQ-015 mem_ack  input  1  memory completion; honoured only in REQ.
REQ-016 mem_rdata  input  16  read data, valid in the cycle mem_ack=1.
REQ-017 timeout  output  1  sticky error flag.

Function
REQ-018 Registered FSM, states IDLE, REQ, DONE; all outputs driven from registers or state decode only (no input-to-output combinational path).
REQ-019 IDLE: cpu_req=1 -> latch cpu_we/cpu_addr/cpu_wdata into mem_we/mem_addr/mem_wdata, clear wait counter, next state REQ; cpu_req=0 -> stay IDLE.
REQ-020 REQ: mem_req=1; mem_we/mem_addr/mem_wdata stable for entire REQ residency.
REQ-021 REQ with mem_ack=1: if mem_we=0 capture mem_rdata into cpu_rdata; next state DONE.
REQ-022 REQ with mem_ack=0: 8-bit wait counter increments; if counter == TIMEOUT_CYCLES-1 -> set timeout=1, cpu_rdata unchanged, next state DONE; else stay REQ.
REQ-023 mem_ack=1 on final allowed REQ cycle SHALL complete normally; timeout not set.
REQ-024 mem_req SHALL be high for at most TIMEOUT_CYCLES consecutive cycles per transaction.
REQ-025 DONE: cpu_done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-026 cpu_req in REQ or DONE ignored; still-high cpu_req in first IDLE cycle after DONE starts a new transaction.
REQ-027 Minimum latency: cpu_req in IDLE at cycle N -> mem_req cycle N+1 -> (ack at N+1) cpu_done at cycle N+2.
REQ-028 Writes never modify cpu_rdata; cpu_rdata holds value until next successful read.
REQ-029 mem_ack in IDLE or DONE SHALL have no effect.
REQ-030 timeout remains 1 until rst; later transactions unaffected by it.

Reset
REQ-031 On posedge clk with rst=1: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_done=0, cpu_busy=0, timeout=0, counter=0.
REQ-032 rst mid-transaction (REQ or DONE) SHALL abort it: no cpu_done pulse, mem_req low from the reset edge.
REQ-033 rst overrides all inputs in the same cycle, including cpu_req and mem_ack.

Verification
REQ-034 Read, zero-wait: cpu_req=1, we=0, addr=16'h3000 at N; mem_ack=1, mem_rdata=16'hBEEF at N+1 -> cpu_done at N+2, cpu_rdata=16'hBEEF, cpu_busy high N+1..N+2.
REQ-035 Write, 3-wait: we=1, addr=16'h0042, wdata=16'h1234; ack on 4th REQ cycle -> mem_addr/mem_wdata stable all 4 cycles, cpu_done one cycle later, cpu_rdata unchanged.
REQ-036 Timeout: TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, timeout=1, one cpu_done pulse; ack on 4th cycle instead -> timeout stays 0.
REQ-037 Back-to-back: cpu_req held high through cpu_done -> second transaction begins the cycle after DONE; cpu_addr change during REQ not reflected on mem_addr.
REQ-038 Reset mid-REQ: rst at 2nd REQ cycle -> all outputs at reset values next cycle, no cpu_done, later read completes normally and timeout=0.
REQ-039 Stray mem_ack=1 while IDLE -> cpu_rdata, cpu_done, state unchanged.

Source files
------------

// File: rtl/punc_mem_bridge_if.sv
// punc_mem_bridge_if: CPU-side and memory-side signals of the PUnC memory bridge
interface punc_mem_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        timeout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_done, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata, timeout
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_done, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata, timeout
  );
endinterface

// File: rtl/punc_mem_bridge.sv
// punc_mem_bridge: single-outstanding CPU-to-memory bridge with bounded wait and sticky timeout
module punc_mem_bridge #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input logic clk,
  input logic rst,
  punc_mem_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        to_q, to_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        we_d    = bus.cpu_we;
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        cnt_d   = 8'd0;
        state_d = REQ;
      end
      REQ: if (bus.mem_ack) begin
        rdata_d = we_q ? rdata_q : bus.mem_rdata;
        state_d = DONE;
      end else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
        to_d    = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end
  assign bus.mem_req   = state_q == REQ;
  assign bus.cpu_done  = state_q == DONE;
  assign bus.cpu_busy  = state_q != IDLE;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.timeout   = to_q;
endmodule
